// File: rtl/cmp_pkg.sv
// Shared types for the serial nibble comparator: slice width, FSM states, result bundle.
package cmp_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic eq;
        logic gt;
        logic lt;
    } cmp_res;

    localparam cmp_res RES_NONE = '{eq: 1'b0, gt: 1'b0, lt: 1'b0};
    localparam cmp_res RES_EQ   = '{eq: 1'b1, gt: 1'b0, lt: 1'b0};

endpackage

// File: rtl/nibble_cmp.sv
// Combinational 4-bit unsigned magnitude slice; exactly one of eq/gt/lt is set.
module nibble_cmp
    import cmp_pkg::*;
(
    input  logic [NIBBLE_W-1:0] i_a,
    input  logic [NIBBLE_W-1:0] i_b,
    output cmp_res              o_res_c
);

    always_comb begin
        o_res_c = RES_NONE;
        if (i_a > i_b) begin
            o_res_c.gt = 1'b1;
        end else if (i_a < i_b) begin
            o_res_c.lt = 1'b1;
        end else begin
            o_res_c.eq = 1'b1;
        end
    end

endmodule

// File: rtl/nibble_serial_compare_ctrl.sv
// Wide-operand compare sequenced one nibble per cycle, MSB first, through a single slice.
// Define CMP_SIGNED_EN to treat operands as two's complement.
module nibble_serial_compare_ctrl
    import cmp_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [NIBBLE_W*NIBBLES-1:0]  a,
    input  logic [NIBBLE_W*NIBBLES-1:0]  b,
    output logic                         busy,
    output logic                         done,
    output logic                         eq,
    output logic                         gt,
    output logic                         lt
);

    localparam int unsigned IDX_W = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NIBBLES - 1);

    state_e                            r_state;
    state_e                            w_state_nxt;
    logic [NIBBLES-1:0][NIBBLE_W-1:0]  r_a;
    logic [NIBBLES-1:0][NIBBLE_W-1:0]  r_b;
    logic [NIBBLES-1:0][NIBBLE_W-1:0]  w_a_nxt;
    logic [NIBBLES-1:0][NIBBLE_W-1:0]  w_b_nxt;
    logic [IDX_W-1:0]                  r_idx;
    logic [IDX_W-1:0]                  w_idx_nxt;
    logic                              r_done;
    logic                              w_done_nxt;
    cmp_res                            r_res;
    cmp_res                            w_res_nxt;
    logic [NIBBLE_W-1:0]               w_nib_a;
    logic [NIBBLE_W-1:0]               w_nib_b;
    cmp_res                            w_slice;

    // Nibble select; in signed mode the sign bit is flipped so the top nibble orders as two's complement.
    always_comb begin
        w_nib_a = r_a[r_idx];
        w_nib_b = r_b[r_idx];
`ifdef CMP_SIGNED_EN
        if (r_idx == IDX_TOP) begin
            w_nib_a[NIBBLE_W-1] = ~w_nib_a[NIBBLE_W-1];
            w_nib_b[NIBBLE_W-1] = ~w_nib_b[NIBBLE_W-1];
        end
`endif
    end

    nibble_cmp u_nibble_cmp (
        .i_a     (w_nib_a),
        .i_b     (w_nib_b),
        .o_res_c (w_slice)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_idx   <= '0;
            r_done  <= 1'b0;
            r_res   <= RES_NONE;
        end else begin
            r_state <= w_state_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_idx   <= w_idx_nxt;
            r_done  <= w_done_nxt;
            r_res   <= w_res_nxt;
        end
    end

    // Stop at the first differing nibble, or report equality once nibble 0 matches.
    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_idx_nxt   = r_idx;
        w_done_nxt  = 1'b0;
        w_res_nxt   = r_res;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_a_nxt     = a;
                    w_b_nxt     = b;
                    w_idx_nxt   = IDX_TOP;
                    w_res_nxt   = RES_NONE;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (!w_slice.eq) begin
                    w_res_nxt   = w_slice;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end else if (r_idx == '0) begin
                    w_res_nxt   = RES_EQ;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_idx_nxt = r_idx - IDX_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (r_state == RUN);
    assign done = r_done;
    assign eq   = r_res.eq;
    assign gt   = r_res.gt;
    assign lt   = r_res.lt;

endmodule

// File: tb/tb_nibble_serial_compare_ctrl.sv
// Scoreboard bench for nibble_serial_compare_ctrl (NIBBLES=4); honours CMP_SIGNED_EN.
module tb_nibble_serial_compare_ctrl;

    localparam int unsigned NIBBLES = 4;
    localparam int unsigned W       = 4 * NIBBLES;

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy, done, eq, gt, lt;

    typedef struct {
        logic [2:0] res;       // {eq, gt, lt}
        int         done_cyc;
    } exp_t;

    exp_t       sb_q[$];
    int         cyc    = 0;
    int         checks = 0;
    int         errors = 0;
    int         m_rem  = 0;
    logic       m_done = 1'b0;
    logic [2:0] m_res  = 3'b000;
    logic [2:0] m_cur  = 3'b000;

    always #5 clk = ~clk;

    nibble_serial_compare_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .eq    (eq),
        .gt    (gt),
        .lt    (lt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference result from whole-word arithmetic.
    function automatic logic [2:0] ref_res(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef CMP_SIGNED_EN
        if ($signed(x) == $signed(y)) return 3'b100;
        return ($signed(x) > $signed(y)) ? 3'b010 : 3'b001;
`else
        if (x == y) return 3'b100;
        return (x > y) ? 3'b010 : 3'b001;
`endif
    endfunction

    // Nibbles examined: position of the highest differing nibble counted from the top.
    function automatic int ref_lat(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] d;
        d = x ^ y;
        for (int i = NIBBLES - 1; i >= 0; i--) begin
            if (d[i*4 +: 4] != 4'h0) return NIBBLES - i;
        end
        return NIBBLES;
    endfunction

    // Transaction-level model: accepts when idle, counts down the expected latency.
    always @(posedge clk) begin
        int n;
        cyc++;
        m_done = 1'b0;
        if (rst) begin
            m_rem = 0;
            m_res = 3'b000;
            sb_q.delete();
        end else if (m_rem == 0) begin
            if (start) begin
                m_cur = ref_res(a, b);
                n     = ref_lat(a, b);
                m_rem = n;
                m_res = 3'b000;
                sb_q.push_back('{res: m_cur, done_cyc: cyc + n});
            end
        end else begin
            m_rem--;
            if (m_rem == 0) begin
                m_res  = m_cur;
                m_done = 1'b1;
            end
        end
    end

    // Monitor: per-cycle handshake/result checks plus scoreboard pop on done.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            check("busy", 32'(busy), 32'(m_rem > 0));
            check("done", 32'(done), 32'(m_done));
            check("held_result", 32'({eq, gt, lt}), 32'(m_res));
            if (done) begin
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("sb_result", 32'({eq, gt, lt}), 32'(e.res));
                    check("sb_latency", 32'(cyc), 32'(e.done_cyc));
                end
            end else if (sb_q.size() != 0 && sb_q[0].done_cyc < cyc) begin
                e = sb_q.pop_front();
                check("sb_missing_done", 32'(cyc), 32'(e.done_cyc));
            end
        end
    end

    task automatic wait_idle();
        int t;
        t = 0;
        while (m_rem != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (m_rem != 0) check("wait_idle_timeout", 32'(m_rem), 32'd0);
    endtask

    task automatic do_cmp(input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        wait_idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] x, y;
        int           nib;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        check("reset_outputs", 32'({busy, done, eq, gt, lt}), 32'd0);

        do_cmp(16'h1234, 16'h1234);
        repeat (3) @(negedge clk);
        do_cmp(16'h8000, 16'h7FFF);
        do_cmp(16'h12A4, 16'h12B4);
        do_cmp(16'h0001, 16'h0000);

        // Start while busy must be ignored.
        @(negedge clk);
        a = 16'h0005; b = 16'h0005; start = 1'b1;
        @(negedge clk);
        a = 16'hFFFF; b = 16'h0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (2) @(negedge clk);

        // Asynchronous reset mid-run.
        @(negedge clk);
        a = 16'hAAAA; b = 16'hAAAA; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check("async_reset_outputs", 32'({busy, done, eq, gt, lt}), 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("no_done_after_reset", 32'(done), 32'd0);
        do_cmp(16'h0010, 16'h0020);

        // Start held across done: second compare accepted in the done cycle.
        @(negedge clk);
        a = 16'h0F00; b = 16'h0E00; start = 1'b1;
        @(negedge clk);
        a = 16'h0003; b = 16'h0002;
        wait_idle();
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Randomized phase: random start pulses, including while busy and in done cycles.
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            x = W'($urandom);
            y = x;
            case ($urandom_range(0, 3))
                0: y = W'($urandom);
                1: ;
                2: begin
                    nib = $urandom_range(0, NIBBLES - 1);
                    y[nib*4 +: 4] = y[nib*4 +: 4] ^ 4'($urandom_range(1, 15));
                end
                default: begin
                    x[W-1] = 1'b1;
                    y[W-1] = 1'b0;
                end
            endcase
            a = x; b = y;
            start = ($urandom_range(0, 2) == 0);
        end
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
